// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port memory bus arbiter for the IF and load/store requesters
//
// Purpose: shares one ack/err terminated memory bus between instruction fetch (IF)
// and load/store (D). D wins ties unless IF has been passed over STARVE_LIMIT times.
// A watchdog ends any transaction that sees no ack/err within TIMEOUT busy cycles.
// The wait flags feed the hazard unit so that it can stall the pipeline.
//
// Ports:
//   clk_i, rst_i     clock; asynchronous active-high reset
//   if_req_i ..      IF read request (address, kill/flush), completion ack/rdata/err, wait flag
//   d_req_i ..       D request (we, address, wdata, byte enables), completion ack/rdata/err, wait flag
//   bus_req_o ..     bus transaction fields, held stable while busy
//   bus_ack_i ..     bus completion (ack/err) and read data
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  input  logic                    if_kill_i,
  output logic                    if_ack_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_err_o,
  output logic                    if_wait_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic                    d_ack_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_err_o,
  output logic                    d_wait_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  input  logic                    bus_ack_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_err_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int SW       = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    TMO_MAX    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [BE_WIDTH-1:0]   bus_be_q, bus_be_d;
  logic                  if_ack_q, if_ack_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  if_err_q, if_err_d;
  logic                  d_ack_q, d_ack_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  d_err_q, d_err_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  kill_q, kill_d;

  // A requester is not pending in its own ack cycle, so a held request is
  // never granted a second time for the same access.
  logic if_pend, d_pend, grant_i, grant_d, busy, tmo_hit, term, term_err;

  assign if_pend  = if_req_i & ~if_ack_q;
  assign d_pend   = d_req_i & ~d_ack_q;
  assign grant_i  = (state_q == IDLE) & if_pend & (~d_pend | (starve_q == STARVE_MAX));
  assign grant_d  = (state_q == IDLE) & d_pend & ~grant_i;
  assign busy     = (state_q == BUSY_I) | (state_q == BUSY_D);
  assign tmo_hit  = (tmo_q == TMO_MAX);
  assign term     = busy & (bus_ack_i | bus_err_i | tmo_hit);
  // ack together with err counts as an error
  assign term_err = bus_err_i | tmo_hit;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    kill_d      = kill_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d     = BUSY_I;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_be_d    = '1;
          starve_d    = '0;
          tmo_d       = 8'd0;
          kill_d      = if_kill_i;  // flush in the granting cycle still applies
        end else if (grant_d) begin
          state_d     = BUSY_D;
          bus_req_d   = 1'b1;
          bus_we_d    = d_we_i;
          bus_addr_d  = d_addr_i;
          bus_wdata_d = d_wdata_i;
          bus_be_d    = d_be_i;
          tmo_d       = 8'd0;
          kill_d      = 1'b0;
          if (!if_pend) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end

      BUSY_I, BUSY_D: begin
        if (term) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          kill_d    = 1'b0;
          if (state_q == BUSY_D) begin
            d_ack_d   = 1'b1;
            d_err_d   = term_err;
            d_rdata_d = term_err ? '0 : bus_rdata_i;
          end else if (!(kill_q || if_kill_i)) begin
            // a killed fetch completes on the bus but is invisible to IF
            if_ack_d   = 1'b1;
            if_err_d   = term_err;
            if_rdata_d = term_err ? '0 : bus_rdata_i;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if ((state_q == BUSY_I) && if_kill_i) begin
            kill_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      starve_q    <= '0;
      tmo_q       <= 8'd0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      kill_q      <= kill_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;
  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;
  assign if_wait_o   = if_req_i & ~if_ack_q;
  assign d_wait_o    = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int SL = 4;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          if_req_i, if_kill_i, if_ack_o, if_err_o, if_wait_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i, d_ack_o, d_err_o, d_wait_o;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i, d_rdata_o;
  logic [BW-1:0] d_be_i;
  logic          bus_req_o, bus_we_o, bus_ack_i, bus_err_i;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o, bus_rdata_i;
  logic [BW-1:0] bus_be_o;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o), .if_wait_o(if_wait_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o), .d_wait_o(d_wait_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_be_o(bus_be_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory responder
  int          mem_wait = 0;
  int          mem_cnt  = 0;
  logic        mem_err  = 1'b0;
  logic        mem_rand = 1'b0;
  logic        mem_fix_en = 1'b0;
  logic [DW-1:0] mem_fix = '0;

  // reference model: who owns the bus this cycle and what each requester should see
  int            m_owner;     // 0 none, 1 IF, 2 D
  int            m_busy_len;  // busy cycles already spent without completion
  int            m_starve;    // D grants in a row that passed over a pending IF
  logic          m_killed;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic          e_if_ack, e_if_err, e_d_ack, e_d_err;
  logic [DW-1:0] e_if_rdata, e_d_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_busy_len = 0; m_starve = 0; m_killed = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    e_if_ack = 1'b0; e_if_err = 1'b0; e_if_rdata = '0;
    e_d_ack = 1'b0; e_d_err = 1'b0; e_d_rdata = '0;
  endtask

  // Applies the arbitration rules to this cycle's inputs, giving the next cycle's expectations.
  task automatic model_step();
    logic ip, dp, n_if_ack, n_d_ack, fail;
    logic [DW-1:0] data;
    ip = if_req_i && !e_if_ack;
    dp = d_req_i && !e_d_ack;
    n_if_ack = 1'b0;
    n_d_ack  = 1'b0;
    if (m_owner == 0) begin
      if (ip && (!dp || m_starve == SL)) begin
        m_owner = 1; m_we = 1'b0; m_addr = if_addr_i; m_wdata = '0; m_be = '1;
        m_starve = 0; m_killed = if_kill_i; m_busy_len = 0;
      end else if (dp) begin
        m_owner = 2; m_we = d_we_i; m_addr = d_addr_i; m_wdata = d_wdata_i; m_be = d_be_i;
        m_starve = ip ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        m_killed = 1'b0; m_busy_len = 0;
      end
    end else if (bus_ack_i || bus_err_i || m_busy_len == TO) begin
      fail = bus_err_i || (m_busy_len == TO);
      data = fail ? '0 : bus_rdata_i;
      if (m_owner == 2) begin
        n_d_ack = 1'b1; e_d_err = fail; e_d_rdata = data;
      end else if (!(m_killed || if_kill_i)) begin
        n_if_ack = 1'b1; e_if_err = fail; e_if_rdata = data;
      end
      m_owner = 0;
      m_killed = 1'b0;
    end else begin
      m_busy_len++;
      if (m_owner == 1 && if_kill_i) m_killed = 1'b1;
    end
    e_if_ack = n_if_ack;
    e_d_ack  = n_d_ack;
  endtask

  task automatic check_outputs();
    chk("bus_req", bus_req_o, m_owner != 0);
    if (m_owner != 0) begin
      chk("bus_addr", bus_addr_o, m_addr);
      chk("bus_wdata", bus_wdata_o, m_wdata);
      chk("bus_we_be", {bus_we_o, bus_be_o}, {m_we, m_be});
    end
    chk("if_ack", if_ack_o, e_if_ack);
    chk("if_err", if_err_o, e_if_err);
    chk("if_rdata", if_rdata_o, e_if_rdata);
    chk("d_ack", d_ack_o, e_d_ack);
    chk("d_err", d_err_o, e_d_err);
    chk("d_rdata", d_rdata_o, e_d_rdata);
    chk("if_wait", if_wait_o, if_req_i && !e_if_ack);
    chk("d_wait", d_wait_o, d_req_i && !e_d_ack);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus_req"}, bus_req_o, 0);
    chk({tag, "_bus_we"}, bus_we_o, 0);
    chk({tag, "_bus_addr"}, bus_addr_o, 0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 0);
    chk({tag, "_bus_be"}, bus_be_o, 0);
    chk({tag, "_if_ack"}, if_ack_o, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_if_err"}, if_err_o, 0);
    chk({tag, "_d_ack"}, d_ack_o, 0);
    chk({tag, "_d_rdata"}, d_rdata_o, 0);
    chk({tag, "_d_err"}, d_err_o, 0);
  endtask

  // one clock: memory answers the bus as seen now, model advances, outputs are checked
  task automatic tick();
    bus_rdata_i = mem_fix_en ? mem_fix : DW'($urandom);
    if (bus_req_o) begin
      if (mem_cnt >= mem_wait) begin
        bus_err_i = mem_err;
        bus_ack_i = mem_err ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_cnt = 0;
        if (mem_rand) begin
          mem_wait = $urandom_range(0, 3);
          mem_err  = ($urandom_range(0, 7) == 0);
        end
      end else begin
        bus_ack_i = 1'b0; bus_err_i = 1'b0; mem_cnt++;
      end
    end else begin
      bus_ack_i = 1'b0; bus_err_i = 1'b0; mem_cnt = 0;
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic wait_ack(input bit for_if, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      got = for_if ? if_ack_o : d_ack_o;
    end
  endtask

  initial begin : main
    bit got, prev_req, if_got, kill_prev;
    int n_d, n_ack, busy_cnt;
    logic [DW-1:0] snap;

    rst_i = 1'b1;
    if_req_i = 0; if_addr_i = '0; if_kill_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    bus_ack_i = 0; bus_err_i = 0; bus_rdata_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_i = 1'b0;

    // 1: zero-wait IF fetch
    mem_wait = 0; mem_fix_en = 1'b1; mem_fix = 32'h0050_0093;
    if_req_i = 1; if_addr_i = 32'h100;
    tick();
    chk("t1_bus_req_c1", bus_req_o, 1);
    chk("t1_bus_be", bus_be_o, 4'hF);
    tick();
    chk("t1_if_ack_c2", if_ack_o, 1);
    chk("t1_if_rdata", if_rdata_o, 32'h0050_0093);
    if_req_i = 0;
    mem_fix_en = 1'b0;
    repeat (2) tick();

    // 2: simultaneous IF and D store, two wait states
    mem_wait = 2;
    if_req_i = 1; if_addr_i = 32'h104;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'h3;
    tick();
    chk("t2_d_first_addr", bus_addr_o, 32'h2000);
    chk("t2_we_be", {bus_we_o, bus_be_o}, 5'h13);
    repeat (3) tick();
    chk("t2_d_ack_c4", d_ack_o, 1);
    d_req_i = 0;
    tick();
    chk("t2_if_req_c5", bus_req_o, 1);
    chk("t2_if_addr_c5", bus_addr_o, 32'h104);
    wait_ack(1'b1, 8, got);
    chk("t2_if_ack_seen", got, 1);
    if_req_i = 0;
    repeat (2) tick();

    // 3: D back to back while IF waits
    mem_wait = 0;
    if_req_i = 1; if_addr_i = 32'h1000;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h3000;
    n_d = 0; if_got = 0; prev_req = 0;
    for (int i = 0; i < 60 && !if_got; i++) begin
      tick();
      if (bus_req_o && !prev_req) begin
        if (bus_addr_o == 32'h1000) if_got = 1;
        else n_d++;
      end
      prev_req = bus_req_o;
      if (d_ack_o) d_addr_i = d_addr_i + 4;
    end
    chk("t3_if_granted", if_got, 1);
    chk("t3_d_grants_bounded", n_d <= SL, 1);
    wait_ack(1'b1, 8, got);
    chk("t3_if_ack_seen", got, 1);
    if_req_i = 0; d_req_i = 0;
    repeat (4) tick();

    // 4: watchdog timeout on a load
    mem_wait = 1000000;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h4000; d_be_i = 4'hF;
    busy_cnt = 0; got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      got = d_ack_o;
      if (bus_req_o) busy_cnt++;
    end
    chk("t4_d_ack", got, 1);
    chk("t4_busy_cycles", busy_cnt, TO + 1);
    chk("t4_d_err", d_err_o, 1);
    chk("t4_d_rdata", d_rdata_o, 0);
    chk("t4_bus_req", bus_req_o, 0);
    d_req_i = 0;
    mem_wait = 0;
    repeat (2) tick();

    // 5: kill an outstanding fetch
    snap = e_if_rdata;
    mem_wait = 2;
    if_req_i = 1; if_addr_i = 32'h300;
    tick();
    if_kill_i = 1;
    tick();
    if_kill_i = 0; if_req_i = 0;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_ack_o) n_ack++;
    end
    chk("t5_no_if_ack", n_ack, 0);
    chk("t5_if_rdata_kept", if_rdata_o, snap);
    chk("t5_idle", bus_req_o, 0);
    mem_wait = 0;
    if_req_i = 1; if_addr_i = 32'h400;
    wait_ack(1'b1, 6, got);
    chk("t5_next_served", got, 1);
    if_req_i = 0;
    repeat (2) tick();

    // 6: reset in the middle of a D transaction
    mem_wait = 5;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h5000; d_wdata_i = 32'h1234_5678; d_be_i = 4'hC;
    repeat (2) tick();
    chk("t6_busy_before_rst", bus_req_o, 1);
    rst_i = 1'b1;
    #1;
    check_all_zero("t6");
    d_req_i = 0; bus_ack_i = 0; bus_err_i = 0; mem_cnt = 0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    model_reset();
    mem_wait = 0; mem_fix_en = 1'b1; mem_fix = 32'h00A0_0113;
    if_req_i = 1; if_addr_i = 32'h500;
    tick();
    chk("t6_bus_req_c1", bus_req_o, 1);
    tick();
    chk("t6_if_ack_c2", if_ack_o, 1);
    chk("t6_if_rdata", if_rdata_o, 32'h00A0_0113);
    if_req_i = 0; mem_fix_en = 1'b0;
    repeat (2) tick();

    // random traffic with wait states, errors and flushes
    mem_rand = 1'b1; mem_wait = 1; mem_err = 1'b0;
    kill_prev = 0;
    for (int i = 0; i < 3000; i++) begin
      if (if_req_i && (if_ack_o || kill_prev)) if_req_i = 0;
      if (!if_req_i && $urandom_range(0, 3) == 0) begin
        if_req_i = 1; if_addr_i = $urandom & ~32'h3;
      end
      if_kill_i = ($urandom_range(0, 15) == 0);
      kill_prev = if_kill_i;
      if (d_req_i && d_ack_o) d_req_i = 0;
      if (!d_req_i && $urandom_range(0, 2) == 0) begin
        d_req_i = 1; d_we_i = 1'($urandom_range(0, 1));
        d_addr_i = $urandom & ~32'h3; d_wdata_i = $urandom; d_be_i = 4'($urandom_range(1, 15));
      end
      tick();
    end
    mem_rand = 1'b0; mem_wait = 0; mem_err = 1'b0;
    if_req_i = 0; d_req_i = 0; if_kill_i = 0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch requester (IF) and the load/store requester (D, from mem stage).
- Supports wait-state memories through an ack/err handshake, with a watchdog timeout.
- Produces per-requester wait flags that the hazard detection unit turns into pipeline stalls.
- Replaces the dual-ported RAM path when the core is connected to a single-port SoC bus.

Parameters:
- ADDR_WIDTH, 32, address width of both requesters and the bus.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- STARVE_LIMIT, 4, number of consecutive D grants while IF is pending before IF is forced a grant.
- TIMEOUT, 255, bus cycles without ack/err before forced error termination; counter is 8 bits.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- if_req_i  in  1  IF request, held until if_ack_o.
- if_addr_i  in  ADDR_WIDTH  IF address, read only.
- if_kill_i  in  1  flush: discard the outstanding or newly granted IF result.
- if_ack_o  out  1  one-cycle IF completion pulse.
- if_rdata_o  out  DATA_WIDTH  IF read data, valid with if_ack_o.
- if_err_o  out  1  IF bus error/timeout, valid with if_ack_o.
- if_wait_o  out  1  if_req_i & ~if_ack_o (combinational), to HDU.
- d_req_i  in  1  D request, held until d_ack_o.
- d_we_i  in  1  D write enable.
- d_addr_i  in  ADDR_WIDTH  D address.
- d_wdata_i  in  DATA_WIDTH  D write data.
- d_be_i  in  DATA_WIDTH/8  D byte enables.
- d_ack_o  out  1  one-cycle D completion pulse.
- d_rdata_o  out  DATA_WIDTH  D read data, valid with d_ack_o.
- d_err_o  out  1  D error, valid with d_ack_o.
- d_wait_o  out  1  d_req_i & ~d_ack_o (combinational).
- bus_req_o  out  1  bus transaction active.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  ADDR_WIDTH  bus address.
- bus_wdata_o  out  DATA_WIDTH  bus write data.
- bus_be_o  out  DATA_WIDTH/8  bus byte enables; all ones for IF.
- bus_ack_i  in  1  transaction complete.
- bus_rdata_i  in  DATA_WIDTH  read data, sampled with bus_ack_i.
- bus_err_i  in  1  transaction error, terminates like ack.

Behaviour:
- Reset (async, any time, including mid-transaction): state IDLE. All registered outputs are 0: bus_*, *_ack_o, *_rdata_o, *_err_o. Starve counter, timeout counter and kill flag are cleared. Any in-flight transaction is abandoned.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - Effective requests are if_req_i & ~if_ack_o and d_req_i & ~d_ack_o. Masking prevents re-granting a requester during its ack cycle.
  - D has priority, unless the starve counter == STARVE_LIMIT and IF is pending; then IF is granted.
  - On a grant, the bus_* registers load the requester's fields, bus_req_o goes to 1 the next cycle, and the state moves to BUSY_I or BUSY_D.
  - IF grants drive bus_we_o=0, bus_wdata_o=0, bus_be_o all ones.
- Starve counter:
  - Increments on each D grant while IF is pending, saturating at STARVE_LIMIT.
  - Clears on an IF grant, or when IF is not pending at a D grant.
- BUSY states:
  - bus_* outputs stay stable until termination.
  - Termination occurs when bus_ack_i | bus_err_i is sampled high, or when the timeout counter reaches TIMEOUT.
  - On termination: bus_req_o=0 the next cycle, the state returns to IDLE, and the requester's ack_o pulses for one cycle the next cycle.
  - rdata_o is loaded with bus_rdata_i, or 0 on error/timeout. err_o = bus_err_i | timeout.
  - If bus_ack_i and bus_err_i are both high, the result is an error.
- Latency:
  - Zero-wait memory: request sampled at cycle 0, bus_req_o at cycle 1, bus_ack_i at cycle 1, ack_o at cycle 2, next grant decided at cycle 2, next bus_req_o at cycle 3.
  - Each wait state adds one cycle.
- Timeout counter: cleared on entering BUSY, increments each BUSY cycle without termination. Reaching TIMEOUT forces termination with err.
- Kill:
  - if_kill_i high during BUSY_I, or in the IDLE cycle that grants IF, sets the kill flag.
  - The bus transaction still completes normally; if_ack_o, if_err_o and the if_rdata_o update are suppressed, and the flag clears at termination.
  - if_kill_i has no effect in BUSY_D or in IDLE without an IF grant.
- D results are never killed.
- rdata_o and err_o hold their last values when ack_o is low.

Test Plan:
1. Zero-wait IF only: if_addr_i=0x100, bus_ack_i same cycle as bus_req_o, bus_rdata_i=0x00500093 -> bus_req_o at cycle 1, if_ack_o at cycle 2 with if_rdata_o=0x00500093, bus_be_o=0xF.
2. Simultaneous IF and D store (d_addr_i=0x2000, d_wdata_i=0xDEADBEEF, d_be_i=0x3), 2 wait states -> D granted first with bus_we_o=1 and bus_be_o=0x3; d_ack_o at cycle 4; IF bus_req_o at cycle 5.
3. Starvation: D requests back to back, IF held -> after 4 consecutive D grants the 5th grant goes to IF while d_req_i is still high.
4. Timeout: bus_ack_i never asserted -> termination after 255 BUSY cycles, d_ack_o=1, d_err_o=1, d_rdata_o=0, bus_req_o=0.
5. Kill: if_kill_i pulsed in BUSY_I, bus_ack_i two cycles later -> no if_ack_o, if_rdata_o unchanged, arbiter back in IDLE and serving the next request.
6. Reset mid-transaction: rst_i asserted in BUSY_D -> immediately bus_req_o=0, d_ack_o=0, all other outputs 0; after release, the first request follows the scenario 1 timing.
